serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b - bin LSB-first over WIDTH cycles
// behind a valid/ready handshake on both operand and result sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             out_valid_q, out_valid_d;

    logic a0, b0, d_bit, br_next;

    assign a0      = a_q[0];
    assign b0      = b_q[0];
    assign d_bit   = a0 ^ b0 ^ br_q;
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        br_d        = br_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // First DONE cycle commits the finished result into the output flops.
                if (!out_valid_q) begin
                    diff_d      = res_q;
                    bout_d      = br_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            br_q        <= br_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomised operands
// against an integer-arithmetic reference with random result stalls.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; optionally pulses a foreign operand set mid-RUN.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, input int stall, input bit interfere);
        int           r;
        int           lat;
        logic [W-1:0] exp_d;
        logic         exp_b;

        r     = int'(ta) - int'(tb) - int'(tbin);
        exp_d = r[W-1:0];
        exp_b = (r < 0);

        for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);

        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        bin       = tbin;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
        check("busy_run", 32'(busy), 32'd1);

        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (interfere && lat == 3) begin
                in_valid = 1'b1;
                a        = 8'hAA;
                b        = 8'h11;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(W + 1));
        check("diff", 32'(diff), 32'(exp_d));
        check("bout", 32'(bout), 32'(exp_b));

        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_diff", 32'(diff), 32'(exp_d));
            check("stall_bout", 32'(bout), 32'(exp_b));
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_diff_held", 32'(diff), 32'(exp_d));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;

        do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
        do_op(8'h00, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'h80, 8'h7F, 1'b1, 0, 1'b0);
        do_op(8'h3C, 8'h3C, 1'b1, 0, 1'b0);
        do_op(8'hFF, 8'h00, 1'b0, 0, 1'b0);
        do_op(8'h12, 8'h34, 1'b1, 5, 1'b0);
        do_op(8'h10, 8'h01, 1'b0, 0, 1'b1);

        // Reset during the 4th RUN cycle discards the partial result.
        in_valid = 1'b1;
        a        = 8'hC3;
        b        = 8'h5A;
        bin      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        do_op(8'h09, 8'h04, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            do_op(ra, rb, rbin, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
